// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter time-sharing one 22b signed x 19b unsigned multiplier across
// N_REQ requesters; results return in accept order with the issuing index and tag.
module myproject_mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int PIPE  = 2,
    parameter int TAG_W = 4,
    localparam int IDW  = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*22-1:0]    req_a,
    input  logic [N_REQ*19-1:0]    req_b,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    input  logic                   stall,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic [TAG_W-1:0]       res_tag,
    output logic [40:0]            res_data,
    output logic                   busy
);

    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   sel;
    logic             acc;
    logic [21:0]      sel_a;
    logic [18:0]      sel_b;
    logic [TAG_W-1:0] sel_tag;

    // Search from ptr upward; the grant depends only on valids, ptr and stall.
    always_comb begin
        int j;
        j         = 0;
        acc       = 1'b0;
        sel       = '0;
        req_ready = '0;
        if (ap_rst_n && !stall) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = (int'(ptr_reg) + k) % N_REQ;
                if (!acc && req_valid[j]) begin
                    acc = 1'b1;
                    sel = IDW'(j);
                end
            end
        end
        if (acc) begin
            req_ready[sel] = 1'b1;
        end
        ptr_next = ptr_reg;
        if (acc) begin
            ptr_next = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
        end
    end

    assign sel_a   = req_a[22*sel +: 22];
    assign sel_b   = req_b[19*sel +: 19];
    assign sel_tag = req_tag[TAG_W*sel +: TAG_W];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Operands that feed the multiplier in front of the output register
    logic             last_v;
    logic [21:0]      last_a;
    logic [18:0]      last_b;
    logic [TAG_W-1:0] last_tag;
    logic [IDW-1:0]   last_id;
    logic             stage_busy;

    generate
        if (PIPE == 1) begin : g_direct
            assign last_v     = acc;
            assign last_a     = sel_a;
            assign last_b     = sel_b;
            assign last_tag   = sel_tag;
            assign last_id    = sel;
            assign stage_busy = 1'b0;
        end else begin : g_stages
            logic [PIPE-2:0]  sv_reg;
            logic [21:0]      sa_reg   [PIPE-1];
            logic [18:0]      sb_reg   [PIPE-1];
            logic [TAG_W-1:0] stag_reg [PIPE-1];
            logic [IDW-1:0]   sid_reg  [PIPE-1];

            // Stage 0 captures the winning lane; later stages only delay.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    sv_reg <= '0;
                    for (int s = 0; s < PIPE - 1; s++) begin
                        sa_reg[s]   <= '0;
                        sb_reg[s]   <= '0;
                        stag_reg[s] <= '0;
                        sid_reg[s]  <= '0;
                    end
                end else if (!stall) begin
                    sv_reg[0]   <= acc;
                    sa_reg[0]   <= sel_a;
                    sb_reg[0]   <= sel_b;
                    stag_reg[0] <= sel_tag;
                    sid_reg[0]  <= sel;
                    for (int s = 1; s < PIPE - 1; s++) begin
                        sv_reg[s]   <= sv_reg[s-1];
                        sa_reg[s]   <= sa_reg[s-1];
                        sb_reg[s]   <= sb_reg[s-1];
                        stag_reg[s] <= stag_reg[s-1];
                        sid_reg[s]  <= sid_reg[s-1];
                    end
                end
            end

            assign last_v     = sv_reg[PIPE-2];
            assign last_a     = sa_reg[PIPE-2];
            assign last_b     = sb_reg[PIPE-2];
            assign last_tag   = stag_reg[PIPE-2];
            assign last_id    = sid_reg[PIPE-2];
            assign stage_busy = |sv_reg;
        end
    endgenerate

    // Signed x zero-extended unsigned at 41 bits is exact: the product always fits.
    logic [40:0] prod;
    assign prod = {{19{last_a[21]}}, last_a} * {22'b0, last_b};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_tag   <= '0;
            res_data  <= '0;
        end else if (!stall) begin
            res_valid <= last_v;
            if (last_v) begin
                res_id   <= last_id;
                res_tag  <= last_tag;
                res_data <= prod;
            end
        end
    end

    assign busy = res_valid | stage_busy;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Randomized bench for myproject_mul_share_arb: a keyed-by-advance model of accepted
// operations predicts every output each cycle, plus directed literal cases.
module tb_myproject_mul_share_arb;

    localparam int N   = 4;
    localparam int P   = 2;
    localparam int TW  = 4;
    localparam int IDW = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*22-1:0]   req_a;
    logic [N*19-1:0]   req_b;
    logic [N*TW-1:0]   req_tag;
    logic              stall;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [TW-1:0]     res_tag;
    logic [40:0]       res_data;
    logic              busy;

    always #5 ap_clk = ~ap_clk;

    myproject_mul_share_arb #(.N_REQ(N), .PIPE(P), .TAG_W(TW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .stall     (stall),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [TW-1:0] tag;
        logic [21:0] a;
        logic [18:0] b;
    } op_t;

    // Operations keyed by the count of non-stalled edges at which they were accepted.
    op_t          ops[int];
    int           m_ptr;
    int           adv;
    int           last_grant;
    logic [IDW-1:0] e_id;
    logic [TW-1:0]  e_tag;
    logic [40:0]    e_data;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [21:0]  corner_a [4];

    function automatic logic [40:0] mulx(logic [21:0] a, logic [18:0] b);
        longint p;
        p = longint'($signed(a)) * longint'({1'b0, b});
        return p[40:0];
    endfunction

    function automatic int model_grant();
        if (!ap_rst_n || stall) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        ops.delete();
        adv        = 0;
        m_ptr      = 0;
        last_grant = -1;
        e_id       = '0;
        e_tag      = '0;
        e_data     = '0;
    endtask

    task automatic check_all();
        int g;
        logic [N-1:0] exp_ready;
        logic ev;
        logic eb;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        ev = ops.exists(adv - P + 1);
        eb = 1'b0;
        for (int k = adv - P + 1; k <= adv; k++) if (ops.exists(k)) eb = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("res_valid", 64'(res_valid), 64'(ev));
        chk("res_id",    64'(res_id),    64'(e_id));
        chk("res_tag",   64'(res_tag),   64'(e_tag));
        chk("res_data",  64'(res_data),  64'(e_data));
        chk("busy",      64'(busy),      64'(eb));
    endtask

    task automatic step();
        int g;
        @(posedge ap_clk);
        g = model_grant();
        last_grant = g;
        if (ap_rst_n && !stall) begin
            adv++;
            if (g >= 0) begin
                op_t o;
                o.id  = g;
                o.tag = req_tag[TW*g +: TW];
                o.a   = req_a[22*g +: 22];
                o.b   = req_b[19*g +: 19];
                ops[adv] = o;
                m_ptr = (g + 1) % N;
            end
            if (ops.exists(adv - P + 1)) begin
                op_t r;
                r = ops[adv - P + 1];
                e_id   = IDW'(r.id);
                e_tag  = r.tag;
                e_data = mulx(r.a, r.b);
            end
        end
        @(negedge ap_clk);
        check_all();
    endtask

    task automatic new_lane(int i);
        req_a[22*i +: 22]  = ($urandom % 4 == 0) ? corner_a[$urandom % 4] : 22'($urandom);
        req_b[19*i +: 19]  = ($urandom % 4 == 0) ? 19'h7FFFF : 19'($urandom);
        req_tag[TW*i +: TW] = TW'($urandom);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (last_grant == i || !req_valid[i]) begin
                new_lane(i);
                req_valid[i] = ($urandom % 3 != 0);
            end
        end
        stall = ($urandom % 8 == 0);
    endtask

    task automatic drain();
        req_valid = '0;
        stall = 1'b0;
        repeat (P + 1) step();
    endtask

    task automatic directed(int lane, logic [21:0] a, logic [18:0] b, logic [40:0] exp, string nm);
        drain();
        req_a[22*lane +: 22]   = a;
        req_b[19*lane +: 19]   = b;
        req_tag[TW*lane +: TW] = TW'(lane + 9);
        req_valid[lane] = 1'b1;
        step();
        req_valid = '0;
        repeat (P - 1) step();
        chk({nm, "_valid"}, 64'(res_valid), 64'd1);
        chk({nm, "_id"},    64'(res_id),    64'(lane));
        chk({nm, "_data"},  64'(res_data),  64'(exp));
    endtask

    initial begin
        logic [40:0] held;
        corner_a[0] = 22'h3FFFFF;
        corner_a[1] = 22'h200000;
        corner_a[2] = 22'h1FFFFF;
        corner_a[3] = 22'h000000;

        ap_rst_n  = 1'b0;
        stall     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) new_lane(i);
        model_reset();
        repeat (3) step();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        ap_rst_n = 1'b1;
        #1;
        chk("first_grant", 64'(req_ready), 64'b0001);

        repeat (300) begin
            step();
            drive_random();
        end

        directed(2, 22'h3FFFFF, 19'h7FFFF, 41'h1FFFFF80001, "single");
        directed(1, 22'h200000, 19'h7FFFF, 41'h10000200000, "ext_neg");
        directed(3, 22'h1FFFFF, 19'h7FFFF, 41'h0FFFFD80001, "ext_pos");

        // Stall with two operations in flight
        drain();
        req_valid = 4'b0011;
        step();
        if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        step();
        if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        held  = res_data;
        stall = 1'b1;
        repeat (3) begin
            step();
            chk("stall_busy",  64'(busy),      64'd1);
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_hold",  64'(res_data),  64'(held));
        end
        stall = 1'b0;
        repeat (P + 1) step();

        // Asynchronous reset with two operations in flight
        drain();
        req_valid = 4'b1100;
        step();
        if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        step();
        if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        #1 ap_rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 64'(res_valid), 64'd0);
        chk("arst_busy",  64'(busy),      64'd0);
        chk("arst_data",  64'(res_data),  64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        repeat (2) step();

        // Fairness from ptr 0 with unique tags
        for (int i = 0; i < N; i++) begin
            new_lane(i);
            req_tag[TW*i +: TW] = TW'(i);
        end
        req_valid = 4'b1111;
        ap_rst_n  = 1'b1;
        #1;
        for (int n = 0; n < 8 + P - 1; n++) begin
            if (n < 8) chk("fair_grant", 64'(req_ready), 64'(1 << (n % 4)));
            step();
            if (n >= P - 1) begin
                chk("fair_valid", 64'(res_valid), 64'd1);
                chk("fair_tag",   64'(res_tag),   64'(n - P + 1));
                chk("fair_id",    64'(res_id),    64'((n - P + 1) % 4));
            end
            if (n < 8 && last_grant >= 0) req_tag[TW*last_grant +: TW] = TW'(n + 4);
            if (n == 7) req_valid = '0;
        end
        repeat (P + 1) step();

        repeat (1500) begin
            step();
            drive_random();
        end
        stall = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/myproject_mul_share_arb.md
Name: myproject_mul_share_arb

Overview:
- Time-shares one 22-bit signed by 19-bit unsigned multiplier (41-bit exact product) between N_REQ requesters.
- Requesters are, for example, the layernorm scale and variance lanes.
- A round-robin arbiter accepts one operand pair per cycle and feeds a PIPE-deep registered multiply pipeline.
- Each result returns with the winning requester's index and tag, so multiplier area is not replicated per lane.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PIPE, 2, register stages from accept edge to result (>=1; first stage is the operand capture).
- TAG_W, 4, width of the opaque tag carried with each operation.
- IDW, derived = max(1, clog2(N_REQ)), width of the requester index.

Ports:
- ap_clk  in  1  clock; all state on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester grant/accept, combinational.
- req_a  in  N_REQ*22  packed signed multiplicands; lane i at [22*i+21:22*i].
- req_b  in  N_REQ*19  packed unsigned multipliers; lane i at [19*i+18:19*i].
- req_tag  in  N_REQ*TAG_W  packed tags.
- stall  in  1  freezes the arbiter and pipeline while high.
- res_valid  out  1  result valid, one cycle per operation.
- res_id  out  IDW  index of the requester that issued the result.
- res_tag  out  TAG_W  tag of that operation.
- res_data  out  41  signed product.
- busy  out  1  high while any pipeline stage holds a valid operation.

Behaviour:
- Reset (ap_rst_n low, asynchronous assert, applied immediately):
  - All stage valid bits cleared; in-flight operations are discarded and never emerge.
  - Round-robin pointer ptr = 0.
  - res_valid = 0, res_id = 0, res_tag = 0, res_data = 0, busy = 0.
  - req_ready = 0 while reset is held.
- Arbitration (combinational):
  - When stall = 0, the first lane i with req_valid[i] = 1, searched from ptr upward modulo N_REQ, gets req_ready[i] = 1.
  - At most one req_ready bit is set. When stall = 1, req_ready is all zero.
  - req_ready never depends on the lane's own data, only on the req_valid vector, ptr and stall.
- Accept: a handshake is req_valid[i] & req_ready[i] at a rising edge.
  - On accept, ptr <= (i+1) mod N_REQ and lane i's a, b, tag and index are captured into stage 1.
  - With no accept, ptr holds.
- Arithmetic: res_data = sign_extend(a, 41) * zero_extend(b, 41), exact. No overflow or rounding is possible; b is never treated as negative.
- Latency:
  - An operation accepted at edge k presents res_valid = 1 in the cycle after edge k+PIPE-1. With PIPE = 1 that is the cycle directly after accept.
  - The multiply occurs between stage 1 and the output register. Intermediate stages only delay.
- Throughput: one accept per non-stalled cycle. Results leave in accept order, back to back, with no bubbles inserted.
- Output:
  - res_valid is a single-cycle pulse per operation. The consumer cannot back-pressure.
  - res_id, res_tag and res_data hold their last values while res_valid = 0.
- Stall = 1:
  - All stage registers, including the output, hold; no accept occurs; ptr holds.
  - A res_valid already high stays high, with the same data, for every stalled cycle. The consumer must qualify it with !stall.
- Simultaneous requests: strict round-robin. With all lanes continuously valid and no stall, grants rotate 0,1,2,3,0,... No lane waits more than N_REQ-1 accepts.
- Requests held across stall are not lost. Requesters must keep valid and data stable until ready.
- busy = OR of all stage valid bits, including the output stage.

Test Plan:
- Reset then idle: hold ap_rst_n low for 3 cycles with req_valid = 4'b1111 -> req_ready = 0, res_valid = 0, busy = 0. After release, lane 0 is granted first.
- Single op, PIPE = 2: lane 2 presents a = 22'h3FFFFF (-1), b = 19'h7FFFF at edge k -> res_valid in the cycle after edge k+1, res_id = 2, res_data = 41'h1FFFFF80001.
- Extreme product: a = 22'h200000 (-2^21), b = 19'h7FFFF -> res_data = 41'h10000200000. A second case, a = 22'h1FFFFF, b = 19'h7FFFF -> res_data = 41'h0FFFFD80001. Check both against the exact value.
- Fairness: all four lanes valid for 8 cycles, each with a unique tag -> grant order 0,1,2,3,0,1,2,3. Results stream in that order with no gaps and matching tags.
- Stall: assert stall for 3 cycles while 2 ops are in flight -> no req_ready, res_data frozen, busy = 1. After release, the remaining results appear in order, none duplicated beyond the stalled cycles.
- Reset mid-operation: drop ap_rst_n while 2 ops are in flight -> outputs go to 0 asynchronously. After release, neither dropped result ever appears and ptr restarts at 0.
